// File: rtl/board_input_conditioner.sv
// Board pin conditioner: two-flop synchronisers and per-bit debouncers for the
// slide switches and the push button, with registered edge/change strobes.
module board_input_conditioner #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic [WIDTH-1:0] switch_raw,
  input  logic             button_raw_n,
  output logic [WIDTH-1:0] sw_clean,
  output logic             btn_clean,
  output logic             btn_press,
  output logic             btn_release,
  output logic             sw_changed
);

  // The button is carried as the top bit of one combined vector so every bit
  // shares the same synchroniser and debounce logic.
  localparam int                NB        = WIDTH + 1;
  localparam logic [CNT_W-1:0]  LIMIT     = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [NB-1:0]     SYNC_IDLE = {1'b1, {WIDTH{1'b0}}};

  logic [NB-1:0]             sync1_r;
  logic [NB-1:0]             sync2_r;
  logic [NB-1:0]             synced_s;
  logic [NB-1:0]             clean_r;
  logic [NB-1:0]             clean_nxt_s;
  logic [NB-1:0]             upd_s;
  logic [NB-1:0][CNT_W-1:0]  cnt_r;
  logic [NB-1:0][CNT_W-1:0]  cnt_nxt_s;
  logic                      btn_press_r;
  logic                      btn_release_r;
  logic                      sw_changed_r;

  // Button is active-low on the pin; flip it so the debouncer sees 1 = pressed.
  assign synced_s = sync2_r ^ SYNC_IDLE;

  // Per-bit debounce: count stable disagreeing cycles, accept at LIMIT.
  always_comb begin
    clean_nxt_s = clean_r;
    cnt_nxt_s   = {NB{{CNT_W{1'b0}}}};
    upd_s       = {NB{1'b0}};
    for (int i = 0; i < NB; i++) begin
      if (synced_s[i] == clean_r[i]) begin
        cnt_nxt_s[i] = {CNT_W{1'b0}};
      end else if (cnt_r[i] >= LIMIT) begin
        clean_nxt_s[i] = synced_s[i];
        upd_s[i]       = 1'b1;
        cnt_nxt_s[i]   = {CNT_W{1'b0}};
      end else begin
        cnt_nxt_s[i] = cnt_r[i] + CNT_ONE;
      end
    end
  end

  // State registers: synchronisers, counters, clean levels and strobes.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      sync1_r       <= SYNC_IDLE;
      sync2_r       <= SYNC_IDLE;
      clean_r       <= {NB{1'b0}};
      cnt_r         <= {NB{{CNT_W{1'b0}}}};
      btn_press_r   <= 1'b0;
      btn_release_r <= 1'b0;
      sw_changed_r  <= 1'b0;
    end else begin
      sync1_r       <= {button_raw_n, switch_raw};
      sync2_r       <= sync1_r;
      clean_r       <= clean_nxt_s;
      cnt_r         <= cnt_nxt_s;
      btn_press_r   <= upd_s[WIDTH] & clean_nxt_s[WIDTH];
      btn_release_r <= upd_s[WIDTH] & ~clean_nxt_s[WIDTH];
      sw_changed_r  <= |upd_s[WIDTH-1:0];
    end
  end

  assign sw_clean    = clean_r[WIDTH-1:0];
  assign btn_clean   = clean_r[WIDTH];
  assign btn_press   = btn_press_r;
  assign btn_release = btn_release_r;
  assign sw_changed  = sw_changed_r;

endmodule

// File: tb/tb_board_input_conditioner.sv
// Directed, table-driven bench for board_input_conditioner with DEBOUNCE_CYCLES=4.
module tb_board_input_conditioner;

  logic       CLOCK_50;
  logic       reset;
  logic [7:0] switch_raw;
  logic       button_raw_n;
  logic [7:0] sw_clean;
  logic       btn_clean;
  logic       btn_press;
  logic       btn_release;
  logic       sw_changed;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic       rst;
    logic [7:0] sw;
    logic       btn_n;
    logic [7:0] e_sw;
    logic       e_btn;
    logic       e_press;
    logic       e_rel;
    logic       e_chg;
  } vec_t;

  vec_t tbl[$];
  vec_t tbl2[$];

  board_input_conditioner #(
    .WIDTH(8),
    .DEBOUNCE_CYCLES(4),
    .CNT_W(20)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .reset(reset),
    .switch_raw(switch_raw),
    .button_raw_n(button_raw_n),
    .sw_clean(sw_clean),
    .btn_clean(btn_clean),
    .btn_press(btn_press),
    .btn_release(btn_release),
    .sw_changed(sw_changed)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic add(input bit second, input logic rst, input logic [7:0] sw, input logic btn_n,
                     input logic [7:0] e_sw, input logic e_btn, input logic e_press,
                     input logic e_rel, input logic e_chg, input int n);
    vec_t v;
    v.rst = rst; v.sw = sw; v.btn_n = btn_n; v.e_sw = e_sw; v.e_btn = e_btn;
    v.e_press = e_press; v.e_rel = e_rel; v.e_chg = e_chg;
    for (int k = 0; k < n; k++) begin
      if (second) tbl2.push_back(v);
      else tbl.push_back(v);
    end
  endtask

  // Drive one row, clock once, sample 1 time unit after the edge.
  task automatic apply_check(input vec_t v, input string name, input int idx);
    logic [11:0] got;
    logic [11:0] exp;
    reset        = v.rst;
    switch_raw   = v.sw;
    button_raw_n = v.btn_n;
    @(posedge CLOCK_50);
    #1;
    got = {sw_clean, btn_clean, btn_press, btn_release, sw_changed};
    exp = {v.e_sw, v.e_btn, v.e_press, v.e_rel, v.e_chg};
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: sw_clean=%h btn_clean=%b press=%b release=%b changed=%b, want sw_clean=%h btn_clean=%b press=%b release=%b changed=%b",
               name, idx, sw_clean, btn_clean, btn_press, btn_release, sw_changed,
               v.e_sw, v.e_btn, v.e_press, v.e_rel, v.e_chg);
    end
  endtask

  initial begin
    vec_t v;
    // Reset with all switches on and button pressed, then release.
    add(0, 1'b1, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3);
    add(0, 1'b0, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 5);
    add(0, 1'b0, 8'hFF, 1'b0, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b1, 1);
    add(0, 1'b0, 8'hFF, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 2);
    // Everything back to idle: release strobe plus change strobe together.
    add(0, 1'b0, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 5);
    add(0, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1);
    add(0, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 2);
    // Clean step 00 -> 5A.
    add(0, 1'b0, 8'h5A, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 5);
    add(0, 1'b0, 8'h5A, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 1);
    add(0, 1'b0, 8'h5A, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 2);
    // Back to 00 so bit 3 can bounce from 0.
    add(0, 1'b0, 8'h00, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 5);
    add(0, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1);
    add(0, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 2);
    // Bounce on bit 3: 1 x3, 0 x1, then 1 stable.
    add(0, 1'b0, 8'h08, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3);
    add(0, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    add(0, 1'b0, 8'h08, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 5);
    add(0, 1'b0, 8'h08, 1'b1, 8'h08, 1'b0, 1'b0, 1'b0, 1'b1, 1);
    add(0, 1'b0, 8'h08, 1'b1, 8'h08, 1'b0, 1'b0, 1'b0, 1'b0, 3);
    // Reset in the middle of a bit-0 count; everything restarts after release.
    add(1, 1'b0, 8'h09, 1'b1, 8'h08, 1'b0, 1'b0, 1'b0, 1'b0, 3);
    add(1, 1'b1, 8'h09, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 2);
    add(1, 1'b0, 8'h09, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 5);
    add(1, 1'b0, 8'h09, 1'b1, 8'h09, 1'b0, 1'b0, 1'b0, 1'b1, 1);
    add(1, 1'b0, 8'h09, 1'b1, 8'h09, 1'b0, 1'b0, 1'b0, 1'b0, 2);

    reset        = 1'b1;
    switch_raw   = 8'hFF;
    button_raw_n = 1'b0;

    for (int i = 0; i < tbl.size(); i++) apply_check(tbl[i], "vec", i);

    // Button held 20 cycles: press at row 6, release 6 rows after raw release.
    for (int i = 1; i <= 32; i++) begin
      v.rst = 1'b0; v.sw = 8'h08; v.btn_n = (i <= 20) ? 1'b0 : 1'b1;
      v.e_sw = 8'h08; v.e_btn = (i >= 6 && i <= 25); v.e_press = (i == 6);
      v.e_rel = (i == 26); v.e_chg = 1'b0;
      apply_check(v, "button", i);
    end

    // Two-cycle glitch on the button never reaches the output.
    for (int i = 1; i <= 12; i++) begin
      v.rst = 1'b0; v.sw = 8'h08; v.btn_n = (i <= 2) ? 1'b0 : 1'b1;
      v.e_sw = 8'h08; v.e_btn = 1'b0; v.e_press = 1'b0; v.e_rel = 1'b0; v.e_chg = 1'b0;
      apply_check(v, "glitch", i);
    end

    for (int i = 0; i < tbl2.size(); i++) apply_check(tbl2[i], "rst_mid", i);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
